// File: rtl/fetch_unit_pkg.sv
// Shared sizing constants, fetch state encoding and address helpers for the
// instruction fetch unit and its program loader.
package fetch_unit_pkg;

    localparam int MEM_DEPTH = 256;
    localparam int ADDR_W    = 14;
    localparam int DATA_W    = 19;

    localparam logic [ADDR_W-1:0] RESET_PC   = '0;
    localparam logic [ADDR_W-1:0] DEPTH_ADDR = ADDR_W'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } fetch_state_e;

    // Sequential successor of a fetch address, wrapping at the top of memory.
    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
        logic [ADDR_W-1:0] nxt;
        nxt = pc + ADDR_W'(1);
        if (pc >= LAST_ADDR) begin
            nxt = '0;
        end
        return nxt;
    endfunction

    function automatic logic [ADDR_W-1:0] addr_wrap(input logic [ADDR_W-1:0] addr);
        return addr % DEPTH_ADDR;
    endfunction

endpackage

// File: rtl/fetch_unit_loader.sv
// Program-load address counter: produces the memory write strobe and flags
// load streams that run past the end of instruction memory.
module fetch_unit_loader
    import fetch_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              enter_i,
    input  logic              active_i,
    input  logic              load_valid_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] count_o,
    output logic              ovf_o
);

    logic [ADDR_W-1:0] count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              full;

    assign full = (count_q == DEPTH_ADDR);

    // Reset gates the strobe directly so a reset cycle can never write memory.
    assign we_o = active_i & load_valid_i & ~full & ~rst;

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (enter_i) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (active_i && load_valid_i) begin
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count_o = count_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/fetch_unit.sv
// Program counter and fetch sequencer in front of the 256 x 19-bit instruction
// memory: streams programs in (LOAD) and presents sequential instructions (RUN).
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic              start,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              halt_req,
    input  logic [DATA_W-1:0] outIM,
    output logic              we_IM,
    output logic [DATA_W-1:0] dataIM,
    output logic [ADDR_W-1:0] addIM,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] load_count,
    output logic              load_ovf,
    output logic              running,
    output logic              halted
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pendValid_q, pendValid_d;
    logic              loadEnter;
    logic              accepted;
    logic [ADDR_W-1:0] targetWrapped;
    logic [ADDR_W-1:0] pcNext;

    fetch_unit_loader u_loader (
        .clk          (clk),
        .rst          (rst),
        .enter_i      (loadEnter),
        .active_i     (state_q == LOAD),
        .load_valid_i (load_valid),
        .we_o         (we_IM),
        .count_o      (load_count),
        .ovf_o        (load_ovf)
    );

    assign targetWrapped = addr_wrap(branch_target);
    assign pcNext        = pc_inc(pc_q);
    assign accepted      = (state_q == RUN) & pendValid_q & ~stall & ~branch_taken;

    assign dataIM   = load_data;
    assign instr    = outIM;
    assign instr_pc = pc_q;
    assign running  = (state_q == RUN);
    assign halted   = (state_q == HALT);

    // addIM is combinational so the registered memory returns the next word
    // exactly when the fetch sequencer advances: one instruction per cycle.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pendValid_d = 1'b0;
        addIM       = pc_q;
        instr_valid = 1'b0;
        loadEnter   = 1'b0;

        case (state_q)
            IDLE, HALT: begin
                if (load_start) begin
                    state_d   = LOAD;
                    loadEnter = 1'b1;
                end else if (start) begin
                    state_d = RUN;
                    pc_d    = RESET_PC;
                end
            end

            LOAD: begin
                addIM = load_count;
                if (load_valid && load_last) begin
                    state_d = IDLE;
                end
            end

            RUN: begin
                instr_valid = pendValid_q;
                pendValid_d = 1'b1;
                if (branch_taken) begin
                    addIM = targetWrapped;
                    pc_d  = targetWrapped;
                end else if (!pendValid_q) begin
                    addIM = pc_q;
                end else if (stall) begin
                    addIM = pc_q;
                end else begin
                    addIM = pcNext;
                    pc_d  = pcNext;
                end
                if (accepted && halt_req) begin
                    state_d     = HALT;
                    pendValid_d = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            pendValid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pendValid_q <= pendValid_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written
// overflow/reset sequences and randomized traffic against a behavioural model.
module tb_fetch_unit;

    localparam int DEPTH  = 256;
    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_RUN  = 2;
    localparam int M_HALT = 3;

    logic        clk = 1'b0;
    logic        rst, load_start, load_valid, load_last, start, stall, branch_taken, halt_req;
    logic [18:0] load_data, outIM, dataIM, instr;
    logic [13:0] branch_target, addIM, instr_pc, load_count;
    logic        we_IM, instr_valid, load_ovf, running, halted;

    logic [18:0] tbMem [DEPTH] = '{default: '0};

    typedef struct {
        bit          rst;
        bit          loadStart;
        bit          loadValid;
        logic [18:0] loadData;
        bit          loadLast;
        bit          start;
        bit          stall;
        bit          br;
        logic [13:0] target;
        bit          haltReq;
    } stim_t;

    typedef struct {
        stim_t s;
        int    expWe;
        int    expAdd;
        int    expValid;
        int    expPc;
        int    expInstr;
        int    expRunning;
        int    expHalted;
        int    expCount;
    } vec_t;

    int testsRun    = 0;
    int testsFailed = 0;

    // Behavioural model: operating mode, fetch address, whether a fetched word
    // is on show, load progress and the model's own view of memory contents.
    int mMode = M_IDLE, mPc = 0, mCount = 0;
    bit mPresent = 1'b0, mOvf = 1'b0;
    int refMem [DEPTH] = '{default: 0};
    int nMode, nPc, nCount, wrAddr, wrData;
    bit nPresent, nOvf, wrPending;
    int eWe, eAdd, eValid, ePc, eInstr, eRunning, eHalted;

    fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .load_start    (load_start),
        .load_valid    (load_valid),
        .load_data     (load_data),
        .load_last     (load_last),
        .start         (start),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halt_req      (halt_req),
        .outIM         (outIM),
        .we_IM         (we_IM),
        .dataIM        (dataIM),
        .addIM         (addIM),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .load_count    (load_count),
        .load_ovf      (load_ovf),
        .running       (running),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    // Instruction memory: write when enabled, otherwise registered read.
    always @(posedge clk) begin
        if (we_IM) tbMem[int'(addIM) % DEPTH] <= dataIM;
        else       outIM <= tbMem[int'(addIM) % DEPTH];
    end

    function automatic stim_t mkStim(input bit ls, input bit lv, input int d, input bit ll,
                                     input bit st, input bit sl, input bit br, input int t,
                                     input bit h);
        stim_t s;
        s.rst = 1'b0; s.loadStart = ls; s.loadValid = lv; s.loadData = 19'(d);
        s.loadLast = ll; s.start = st; s.stall = sl; s.br = br; s.target = 14'(t);
        s.haltReq = h;
        return s;
    endfunction

    function automatic vec_t mkVec(input stim_t s, input int we, input int add, input int v,
                                   input int pc, input int ins, input int run, input int hlt,
                                   input int cnt);
        vec_t r;
        r.s = s; r.expWe = we; r.expAdd = add; r.expValid = v; r.expPc = pc;
        r.expInstr = ins; r.expRunning = run; r.expHalted = hlt; r.expCount = cnt;
        return r;
    endfunction

    function automatic stim_t randomStim();
        stim_t s;
        s.rst       = ($urandom_range(0, 99) == 0);
        s.loadStart = ($urandom_range(0, 29) == 0);
        s.loadValid = ($urandom_range(0, 1) == 1);
        s.loadData  = 19'($urandom);
        s.loadLast  = ($urandom_range(0, 15) == 0);
        s.start     = ($urandom_range(0, 9) == 0);
        s.stall     = ($urandom_range(0, 3) == 0);
        s.br        = ($urandom_range(0, 7) == 0);
        s.target    = 14'($urandom);
        s.haltReq   = ($urandom_range(0, 15) == 0);
        return s;
    endfunction

    task automatic modelEval(input stim_t s);
        eWe = 0; eAdd = mPc; eValid = 0; ePc = mPc; eInstr = refMem[mPc % DEPTH];
        eRunning = (mMode == M_RUN) ? 1 : 0;
        eHalted  = (mMode == M_HALT) ? 1 : 0;
        nMode = mMode; nPc = mPc; nCount = mCount; nPresent = 1'b0; nOvf = mOvf;
        wrPending = 1'b0; wrAddr = 0; wrData = 0;
        case (mMode)
            M_IDLE, M_HALT: begin
                if (s.loadStart) begin
                    nMode = M_LOAD; nCount = 0; nOvf = 1'b0;
                end else if (s.start) begin
                    nMode = M_RUN; nPc = 0;
                end
            end
            M_LOAD: begin
                eAdd = mCount;
                if (s.loadValid) begin
                    if (mCount >= DEPTH) begin
                        nOvf = 1'b1;
                    end else begin
                        eWe = 1; wrPending = 1'b1; wrAddr = mCount; wrData = int'(s.loadData);
                        nCount = mCount + 1;
                    end
                    if (s.loadLast) nMode = M_IDLE;
                end
            end
            default: begin
                eValid = mPresent ? 1 : 0;
                nPresent = 1'b1;
                if (s.br) begin
                    nPc = int'(s.target) % DEPTH;
                    eAdd = nPc;
                end else if (mPresent && !s.stall) begin
                    nPc = (mPc + 1) % DEPTH;
                    eAdd = nPc;
                    if (s.haltReq) begin
                        nMode = M_HALT; nPresent = 1'b0;
                    end
                end
            end
        endcase
        if (s.rst) begin
            eWe = 0; wrPending = 1'b0;
            nMode = M_IDLE; nPc = 0; nCount = 0; nPresent = 1'b0; nOvf = 1'b0;
        end
    endtask

    task automatic modelCommit();
        if (wrPending) refMem[wrAddr] = wrData;
        mMode = nMode; mPc = nPc; mCount = nCount; mPresent = nPresent; mOvf = nOvf;
    endtask

    task automatic checkVal(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        rst = s.rst; load_start = s.loadStart; load_valid = s.loadValid;
        load_data = s.loadData; load_last = s.loadLast; start = s.start;
        stall = s.stall; branch_taken = s.br; branch_target = s.target;
        halt_req = s.haltReq;
        modelEval(s);
    endtask

    task automatic finishCycle();
        @(posedge clk);
        modelCommit();
        #1;
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, " we_IM"}, int'(we_IM), eWe);
        checkVal({tag, " addIM"}, int'(addIM), eAdd);
        checkVal({tag, " instr_valid"}, int'(instr_valid), eValid);
        if (eValid != 0) begin
            checkVal({tag, " instr_pc"}, int'(instr_pc), ePc);
            checkVal({tag, " instr"}, int'(instr), eInstr);
        end
        if (eWe != 0) checkVal({tag, " dataIM"}, int'(dataIM), wrData);
        checkVal({tag, " running"}, int'(running), eRunning);
        checkVal({tag, " halted"}, int'(halted), eHalted);
        checkVal({tag, " load_count"}, int'(load_count), mCount);
        checkVal({tag, " load_ovf"}, int'(load_ovf), int'(mOvf));
    endtask

    task automatic checkVector(input int idx, input vec_t v);
        string t;
        t = $sformatf("vec%0d", idx);
        checkVal({t, " we_IM"}, int'(we_IM), v.expWe);
        checkVal({t, " addIM"}, int'(addIM), v.expAdd);
        checkVal({t, " instr_valid"}, int'(instr_valid), v.expValid);
        if (v.expValid != 0) begin
            checkVal({t, " instr_pc"}, int'(instr_pc), v.expPc);
            checkVal({t, " instr"}, int'(instr), v.expInstr);
        end
        if (v.expWe != 0) checkVal({t, " dataIM"}, int'(dataIM), int'(v.s.loadData));
        checkVal({t, " running"}, int'(running), v.expRunning);
        checkVal({t, " halted"}, int'(halted), v.expHalted);
        checkVal({t, " load_count"}, int'(load_count), v.expCount);
    endtask

    task automatic runCycle(input stim_t s, input bit useModel);
        applyStimulus(s);
        @(negedge clk);
        if (useModel) checkOutput("rand");
        finishCycle();
    endtask

    initial begin
        vec_t  vecs [29];
        stim_t nop, rstS, s;

        nop  = mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rstS = nop;
        rstS.rst = 1'b1;

        // Load 4 words, run them, then stall / branch / wrap / halt / restart.
        vecs[0]  = mkVec(mkStim(1, 0, 0, 0, 0, 0, 0, 0, 0),       0, 0,    0, 0,   0,       0, 0, 0);
        vecs[1]  = mkVec(mkStim(0, 1, 'h11, 0, 0, 0, 0, 0, 0),    1, 0,    0, 0,   0,       0, 0, 0);
        vecs[2]  = mkVec(mkStim(0, 1, 'h22, 0, 1, 0, 0, 0, 0),    1, 1,    0, 0,   0,       0, 0, 1);
        vecs[3]  = mkVec(mkStim(0, 1, 'h33, 0, 0, 0, 0, 0, 0),    1, 2,    0, 0,   0,       0, 0, 2);
        vecs[4]  = mkVec(mkStim(0, 1, 'h44, 1, 0, 0, 0, 0, 0),    1, 3,    0, 0,   0,       0, 0, 3);
        vecs[5]  = mkVec(nop,                                     0, 0,    0, 0,   0,       0, 0, 4);
        vecs[6]  = mkVec(mkStim(0, 0, 0, 0, 1, 0, 0, 0, 0),       0, 0,    0, 0,   0,       0, 0, 4);
        vecs[7]  = mkVec(nop,                                     0, 0,    0, 0,   0,       1, 0, 4);
        vecs[8]  = mkVec(nop,                                     0, 1,    1, 0,   'h11,    1, 0, 4);
        vecs[9]  = mkVec(nop,                                     0, 2,    1, 1,   'h22,    1, 0, 4);
        vecs[10] = mkVec(nop,                                     0, 3,    1, 2,   'h33,    1, 0, 4);
        vecs[11] = mkVec(nop,                                     0, 4,    1, 3,   'h44,    1, 0, 4);
        vecs[12] = mkVec(mkStim(0, 0, 0, 0, 0, 0, 1, 1, 0),       0, 1,    1, 4,   0,       1, 0, 4);
        vecs[13] = mkVec(mkStim(0, 0, 0, 0, 0, 1, 0, 0, 1),       0, 1,    1, 1,   'h22,    1, 0, 4);
        vecs[14] = mkVec(mkStim(0, 0, 0, 0, 0, 1, 0, 0, 0),       0, 1,    1, 1,   'h22,    1, 0, 4);
        vecs[15] = mkVec(mkStim(0, 0, 0, 0, 0, 1, 0, 0, 0),       0, 1,    1, 1,   'h22,    1, 0, 4);
        vecs[16] = mkVec(nop,                                     0, 2,    1, 1,   'h22,    1, 0, 4);
        vecs[17] = mkVec(mkStim(0, 0, 0, 0, 0, 0, 1, 0, 0),       0, 0,    1, 2,   'h33,    1, 0, 4);
        vecs[18] = mkVec(mkStim(0, 0, 0, 0, 0, 1, 1, 3, 0),       0, 3,    1, 0,   'h11,    1, 0, 4);
        vecs[19] = mkVec(nop,                                     0, 4,    1, 3,   'h44,    1, 0, 4);
        vecs[20] = mkVec(nop,                                     0, 5,    1, 4,   0,       1, 0, 4);
        vecs[21] = mkVec(mkStim(0, 0, 0, 0, 0, 0, 1, 'h1FF, 0),   0, 'hFF, 1, 5,   0,       1, 0, 4);
        vecs[22] = mkVec(nop,                                     0, 0,    1, 255, 0,       1, 0, 4);
        vecs[23] = mkVec(mkStim(0, 0, 0, 0, 0, 0, 0, 0, 1),       0, 1,    1, 0,   'h11,    1, 0, 4);
        vecs[24] = mkVec(nop,                                     0, 1,    0, 0,   0,       0, 1, 4);
        vecs[25] = mkVec(nop,                                     0, 1,    0, 0,   0,       0, 1, 4);
        vecs[26] = mkVec(mkStim(0, 0, 0, 0, 1, 0, 0, 0, 0),       0, 1,    0, 0,   0,       0, 1, 4);
        vecs[27] = mkVec(nop,                                     0, 0,    0, 0,   0,       1, 0, 4);
        vecs[28] = mkVec(nop,                                     0, 1,    1, 0,   'h11,    1, 0, 4);

        applyStimulus(rstS);
        finishCycle();
        applyStimulus(rstS);
        finishCycle();

        applyStimulus(nop);
        @(negedge clk);
        checkVal("reset running", int'(running), 0);
        checkVal("reset halted", int'(halted), 0);
        checkVal("reset instr_valid", int'(instr_valid), 0);
        checkVal("reset load_count", int'(load_count), 0);
        checkVal("reset load_ovf", int'(load_ovf), 0);
        checkVal("reset addIM", int'(addIM), 0);
        checkVal("reset we_IM", int'(we_IM), 0);
        finishCycle();

        for (int i = 0; i < 29; i++) begin
            applyStimulus(vecs[i].s);
            @(negedge clk);
            checkVector(i, vecs[i]);
            finishCycle();
        end

        // Overflow: 257 beats, simultaneous load_start/start enters LOAD.
        runCycle(rstS, 1'b0);
        runCycle(mkStim(1, 0, 0, 0, 1, 0, 0, 0, 0), 1'b0);
        for (int i = 0; i <= 256; i++) begin
            s = mkStim(0, 1, 'h100 + i, (i == 256), 0, 0, 0, 0, 0);
            applyStimulus(s);
            @(negedge clk);
            if (i == 0) begin
                checkVal("ovf first beat we_IM", int'(we_IM), 1);
                checkVal("ovf load beats start running", int'(running), 0);
            end
            if (i == 256) begin
                checkVal("ovf beat257 we_IM", int'(we_IM), 0);
                checkVal("ovf beat257 load_count", int'(load_count), 256);
            end
            finishCycle();
        end
        applyStimulus(nop);
        @(negedge clk);
        checkVal("ovf load_count", int'(load_count), 256);
        checkVal("ovf load_ovf", int'(load_ovf), 1);
        checkVal("ovf back to idle", int'(running) + int'(halted), 0);
        checkVal("ovf mem0 kept", int'(tbMem[0]), 'h100);
        checkVal("ovf mem255", int'(tbMem[255]), 'h1FF);
        finishCycle();

        runCycle(mkStim(1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        applyStimulus(nop);
        @(negedge clk);
        checkVal("reload clears load_ovf", int'(load_ovf), 0);
        checkVal("reload clears load_count", int'(load_count), 0);
        finishCycle();

        // Reset coincident with a load beat.
        runCycle(mkStim(0, 1, 'h5A5A, 0, 0, 0, 0, 0, 0), 1'b0);
        s = mkStim(0, 1, 'h7777, 0, 0, 0, 0, 0, 0);
        s.rst = 1'b1;
        applyStimulus(s);
        @(negedge clk);
        checkVal("rst-load we_IM", int'(we_IM), 0);
        finishCycle();
        applyStimulus(mkStim(0, 1, 'h1234, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        checkVal("post-rst idle we_IM", int'(we_IM), 0);
        checkVal("post-rst load_count", int'(load_count), 0);
        checkVal("post-rst running", int'(running), 0);
        finishCycle();
        checkVal("rst-load mem1 kept", int'(tbMem[1]), 'h101);
        checkVal("rst-load mem0 written", int'(tbMem[0]), 'h5A5A);

        for (int n = 0; n < 3000; n++) begin
            runCycle(randomStim(), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
